fifo_enq_arbiter: RTL and testbench
===================================

Name: fifo_enq_arbiter

Overview:
- Shares the single enqueue port of one `fifo` instance among N independent valid/ready producers.
- Uses round-robin priority with an optional short burst hold. Once a requester starts a burst, it keeps the grant for up to BURST consecutive transfers, which reduces interleaving of related words.
- Sits directly in front of the FIFO's enq_val/enq_data/enq_rdy.
- Purely a controller: holds no data storage; the data path is a mux.

Parameters:
- N, 4, number of requesters (2..16)
- WIDTH, 8, data width; must match the downstream FIFO WIDTH
- BURST, 4, maximum consecutive transfers per grant (>=1; 1 = pure per-transfer round-robin)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_val  input  N  per-requester valid; bit i = requester i
- in_data  input  N*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
- in_rdy  output  N  per-requester ready, one-hot or zero
- out_val  output  1  to FIFO enq_val
- out_data  output  WIDTH  to FIFO enq_data
- out_rdy  input  1  from FIFO enq_rdy

Behaviour:
- Reset, asynchronous:
  - Registers: ptr=0, locked=0, owner=0, cnt=0.
  - While reset is high: out_val=0, in_rdy=0, out_data=0.
- State is {locked, owner, ptr, cnt}:
  - ptr = highest-priority index when unlocked.
  - cnt = transfers done in the current burst (width clog2(BURST+1)).
- Grant is combinational from in_val and state only, never from out_rdy, so there is no combinational loop through the FIFO.
- UNLOCKED (locked=0):
  - grant g = first i with in_val[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - No in_val set -> no grant.
- LOCKED (locked=1):
  - grant g = owner if in_val[owner]=1; otherwise no grant that cycle. Other requesters are never granted while locked.
- Datapath:
  - out_val = grant exists.
  - out_data = in_data[g]; 0 when there is no grant.
  - in_rdy[g] = out_rdy; all other in_rdy bits = 0.
  - fire = out_val & out_rdy.
- Transitions, registered on posedge clk:
  - UNLOCKED, fire, BURST==1: ptr <= (g+1) mod N; stay UNLOCKED.
  - UNLOCKED, fire, BURST>1: locked<=1, owner<=g, cnt<=1.
  - LOCKED, fire, cnt+1==BURST: locked<=0, cnt<=0, ptr<=(owner+1) mod N.
  - LOCKED, fire, cnt+1<BURST: cnt<=cnt+1.
  - LOCKED, in_val[owner]=0: locked<=0, cnt<=0, ptr<=(owner+1) mod N. This costs exactly one bubble cycle.
  - LOCKED, in_val[owner]=1, out_rdy=0 (FIFO full): hold all state; the burst is not broken by backpressure.
  - No fire and not an abandon case: hold.
- Wrap-around: ptr and owner+1 wrap to 0 at N-1. Works for non-power-of-2 N.
- Fairness: every continuously valid requester is granted within (N-1)*BURST + N transfers.
- Reset mid-burst: lock and counter are cleared immediately; the next grant after reset follows ptr=0.
- Latency: zero-cycle combinational pass-through; one transfer per cycle maximum.

Optional Feature:
- Macro: FIFO_ENQ_ARB_ID_EN.
- Defined:
  - Extra output port out_id [clog2(N)-1:0] = g, the source index of the current out_data; 0 when out_val=0 or during reset.
  - Intended to be stored alongside data (widen the FIFO by clog2(N)).
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared header fifo_arb_defs.vh:
  - clog2 function used for LOGN and cnt widths.
  - Default N/BURST localparams.
  - FIFO_ENQ_ARB_ID_EN documentation.
- One sub-module, rr_pick:
  - Combinational cyclic priority encoder.
  - Inputs: req[N], ptr[LOGN]. Outputs: any, idx[LOGN].
  - Instantiated once; the top adds the lock/burst sequencing and the data mux.
- Reference integration test: fifo_enq_arbiter feeding fifo(WIDTH=8, LOGDEPTH=3).

Test Plan:
- Single requester: N=4, BURST=4, in_val=0001, out_rdy=1, data 0x10..0x15 -> six transfers back-to-back. Grant stays 0. Lock is released after 4 transfers and requester 0 is re-granted with no bubble: ptr=1 and only requester 0 is valid.
- All requesting: BURST=1, in_val=1111 constant, out_rdy=1 -> grant order 0,1,2,3,0,1,... with one transfer per cycle.
- Burst rotation: BURST=2, in_val=1111, out_rdy=1 -> grant order 0,0,1,1,2,2,3,3,0.
- Backpressure: locked on owner 2 with cnt=1, out_rdy=0 for 3 cycles -> out_val=1, in_rdy=0000, state frozen. When out_rdy returns, owner 2 completes the burst, then the grant moves to 3.
- Owner abandons: locked on 1, in_val goes 1111->1101 -> one cycle with out_val=0. The next cycle grants 2, with ptr=2.
- Reset mid-burst: assert reset during lock on owner 3 -> out_val/in_rdy=0 immediately. After deassert with in_val=1111, the first grant goes to 0. With FIFO_ENQ_ARB_ID_EN, out_id tracks the grant and end-to-end FIFO dequeue order matches the arbitration order.

Source files
------------

// File: rtl/fifo_enq_arbiter_pkg.sv
// Shared definitions for the FIFO enqueue arbiter: default sizes, lock state, clog2.
// Optional build macro FIFO_ENQ_ARB_ID_EN adds an out_id port carrying the granted source index.
package fifo_enq_arbiter_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_BURST = 4;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

  // Minimum of 1 so that single-entry widths never collapse to zero bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// Combinational cyclic priority encoder: first set request at or after ptr_i, wrapping mod N.
module fifo_enq_arbiter_rr_pick
  import fifo_enq_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int LOGN = clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [LOGN-1:0] ptr_i,
  output logic            any_o,
  output logic [LOGN-1:0] idx_o
);

  int              cand;
  logic [LOGN-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = LOGN'(cand);
      if (req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter with burst hold sharing one FIFO enqueue port among N valid/ready producers.
// Define FIFO_ENQ_ARB_ID_EN to add out_id (granted source index, 0 when idle or in reset).
module fifo_enq_arbiter
  import fifo_enq_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int BURST = DEF_BURST,
  localparam int LOGN = clog2(N),
  localparam int CNTW = clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_val,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_rdy,
  output logic                 out_val,
  output logic [WIDTH-1:0]     out_data,
`ifdef FIFO_ENQ_ARB_ID_EN
  output logic [LOGN-1:0]      out_id,
`endif
  input  logic                 out_rdy
);

  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);

  arb_state_e      state_q, state_d;
  logic [LOGN-1:0] owner_q, owner_d;
  logic [LOGN-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            pick_any;
  logic [LOGN-1:0] pick_idx;
  logic            gnt_any;
  logic [LOGN-1:0] gnt_idx;
  logic            fire;

  function automatic logic [LOGN-1:0] wrap_inc(input logic [LOGN-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  fifo_enq_arbiter_rr_pick #(.N(N)) u_pick (
    .req_i (in_val),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Grant never looks at out_rdy, so no combinational path runs back through the FIFO.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!reset) begin
      if (state_q == ST_LOCKED) begin
        gnt_any = in_val[owner_q];
        gnt_idx = owner_q;
      end else begin
        gnt_any = pick_any;
        gnt_idx = pick_idx;
      end
    end
  end

  always_comb begin
    out_val  = gnt_any;
    out_data = gnt_any ? in_data[gnt_idx*WIDTH +: WIDTH] : '0;
    fire     = gnt_any & out_rdy;
    for (int i = 0; i < N; i++) begin
      in_rdy[i] = fire && (gnt_idx == LOGN'(i));
    end
  end

`ifdef FIFO_ENQ_ARB_ID_EN
  assign out_id = gnt_any ? gnt_idx : '0;
`endif

  // Backpressure with the owner still valid holds the burst; a departing owner ends it.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == ST_LOCKED) begin
      if (!in_val[owner_q] || (out_rdy && cnt_q == CNT_LAST)) begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
        ptr_d   = wrap_inc(owner_q);
      end else if (out_rdy) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (fire) begin
      if (BURST == 1) begin
        ptr_d = wrap_inc(gnt_idx);
      end else begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
        cnt_d   = CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: four instances (BURST 4/1/2 at N=4, BURST 3 at N=3) on shared stimulus.
// Directed vector table plus randomized traffic against a behavioural reference model.
module tb_fifo_enq_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_val;
  logic [31:0] in_data;
  logic        out_rdy;

  always #5 clk = ~clk;

  logic [3:0] ir_b4, ir_b1, ir_b2;
  logic [2:0] ir_n3;
  logic       ov_b4, ov_b1, ov_b2, ov_n3;
  logic [7:0] od_b4, od_b1, od_b2, od_n3;
  logic [1:0] oid_b4, oid_b1, oid_b2, oid_n3;

  logic [3:0] ir  [4];
  logic       ov  [4];
  logic [7:0] od  [4];
  logic [1:0] oid [4];

  fifo_enq_arbiter #(.N(4), .WIDTH(8), .BURST(4)) u_b4 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_data(in_data), .in_rdy(ir_b4),
    .out_val(ov_b4), .out_data(od_b4),
`ifdef FIFO_ENQ_ARB_ID_EN
    .out_id(oid_b4),
`endif
    .out_rdy(out_rdy));

  fifo_enq_arbiter #(.N(4), .WIDTH(8), .BURST(1)) u_b1 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_data(in_data), .in_rdy(ir_b1),
    .out_val(ov_b1), .out_data(od_b1),
`ifdef FIFO_ENQ_ARB_ID_EN
    .out_id(oid_b1),
`endif
    .out_rdy(out_rdy));

  fifo_enq_arbiter #(.N(4), .WIDTH(8), .BURST(2)) u_b2 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_data(in_data), .in_rdy(ir_b2),
    .out_val(ov_b2), .out_data(od_b2),
`ifdef FIFO_ENQ_ARB_ID_EN
    .out_id(oid_b2),
`endif
    .out_rdy(out_rdy));

  fifo_enq_arbiter #(.N(3), .WIDTH(8), .BURST(3)) u_n3 (
    .clk(clk), .reset(reset), .in_val(in_val[2:0]), .in_data(in_data[23:0]), .in_rdy(ir_n3),
    .out_val(ov_n3), .out_data(od_n3),
`ifdef FIFO_ENQ_ARB_ID_EN
    .out_id(oid_n3),
`endif
    .out_rdy(out_rdy));

`ifndef FIFO_ENQ_ARB_ID_EN
  assign oid_b4 = '0;
  assign oid_b1 = '0;
  assign oid_b2 = '0;
  assign oid_n3 = '0;
`endif

  always_comb begin
    ir[0] = ir_b4; ir[1] = ir_b1; ir[2] = ir_b2; ir[3] = {1'b0, ir_n3};
    ov[0] = ov_b4; ov[1] = ov_b1; ov[2] = ov_b2; ov[3] = ov_n3;
    od[0] = od_b4; od[1] = od_b1; od[2] = od_b2; od[3] = od_n3;
    oid[0] = oid_b4; oid[1] = oid_b1; oid[2] = oid_b2; oid[3] = oid_n3;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: burst owner, transfers taken, and where the rotation resumes.
  int mn [4] = '{4, 4, 4, 3};
  int mb [4] = '{4, 1, 2, 3};
  bit lk  [4];
  int own [4];
  int ptr [4];
  int cnt [4];

  function automatic int m_grant(int k, logic [3:0] v);
    if (lk[k]) return v[own[k]] ? own[k] : -1;
    for (int o = 0; o < mn[k]; o++) begin
      int j;
      j = (ptr[k] + o) % mn[k];
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_advance(int k, logic [3:0] v, logic rdy);
    int g;
    g = m_grant(k, v);
    if (lk[k]) begin
      if (!v[own[k]]) begin
        lk[k] = 0; cnt[k] = 0; ptr[k] = (own[k] + 1) % mn[k];
      end else if (rdy) begin
        cnt[k]++;
        if (cnt[k] == mb[k]) begin
          lk[k] = 0; cnt[k] = 0; ptr[k] = (own[k] + 1) % mn[k];
        end
      end
    end else if (g >= 0 && rdy) begin
      if (mb[k] == 1) ptr[k] = (g + 1) % mn[k];
      else begin
        lk[k] = 1; own[k] = g; cnt[k] = 1;
      end
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      lk[k] = 0; own[k] = 0; ptr[k] = 0; cnt[k] = 0;
    end
  endtask

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, int k, int g);
    chk({tag, "_out_val"}, k, 32'(ov[k]), 32'(g >= 0));
    chk({tag, "_out_data"}, k, 32'(od[k]), (g >= 0) ? 32'(in_data[g*8 +: 8]) : 32'd0);
    chk({tag, "_in_rdy"}, k, 32'(ir[k]), (g >= 0 && out_rdy) ? (32'd1 << g) : 32'd0);
`ifdef FIFO_ENQ_ARB_ID_EN
    chk({tag, "_out_id"}, k, 32'(oid[k]), (g >= 0) ? 32'(g) : 32'd0);
`endif
  endtask

  task automatic step(logic [3:0] v, logic rdy, logic [31:0] d);
    in_val = v; out_rdy = rdy; in_data = d;
    #1;
    for (int k = 0; k < 4; k++) check_outputs("model", k, m_grant(k, v));
    @(posedge clk);
    for (int k = 0; k < 4; k++) m_advance(k, v, rdy);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) check_outputs("reset", k, -1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic       rdy;
    int         g4;
    int         g1;
    int         g2;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, logic [3:0] v, logic rdy, int g4, int g1, int g2);
    vec_t e;
    e.rst = rst; e.v = v; e.rdy = rdy; e.g4 = g4; e.g1 = g1; e.g2 = g2;
    tbl.push_back(e);
  endfunction

  localparam logic [31:0] TAG_DATA = 32'hA3A2A1A0;

  initial begin
    logic [3:0] rv;
    int gexp [3];

    reset = 1'b1; in_val = '0; in_data = '0; out_rdy = 1'b0;
    m_reset();

    // All requesting: pure round-robin, BURST=2 pairs, BURST=4 quads.
    add(1, 4'b1111, 1, 0, 0, 0);
    add(0, 4'b1111, 1, 0, 1, 0);
    add(0, 4'b1111, 1, 0, 2, 1);
    add(0, 4'b1111, 1, 0, 3, 1);
    add(0, 4'b1111, 1, 1, 0, 2);
    add(0, 4'b1111, 1, 1, 1, 2);
    add(0, 4'b1111, 1, 1, 2, 3);
    add(0, 4'b1111, 1, 1, 3, 3);
    add(0, 4'b1111, 1, 2, 0, 0);
    // Backpressure while locked on owner 2.
    add(1, 4'b0100, 1, 2, 2, 2);
    add(0, 4'b1111, 0, 2, 3, 2);
    add(0, 4'b1111, 0, 2, 3, 2);
    add(0, 4'b1111, 0, 2, 3, 2);
    add(0, 4'b1111, 1, 2, 3, 2);
    add(0, 4'b1111, 1, 2, 0, 3);
    add(0, 4'b1111, 1, 2, 1, 3);
    add(0, 4'b1111, 1, 3, 2, 0);
    // Owner 1 abandons: one bubble, then 2.
    add(1, 4'b0010, 1, 1, 1, 1);
    add(0, 4'b1101, 1, -1, 2, -1);
    add(0, 4'b1101, 1, 2, 3, 2);
    // Single requester: no bubble at burst boundary.
    add(1, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0001, 1, 0, 0, 0);

    @(negedge clk);
    apply_reset();

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      in_val = tbl[i].v; out_rdy = tbl[i].rdy; in_data = TAG_DATA;
      #1;
      gexp[0] = tbl[i].g4; gexp[1] = tbl[i].g1; gexp[2] = tbl[i].g2;
      for (int k = 0; k < 3; k++) check_outputs("table", k, gexp[k]);
      step(tbl[i].v, tbl[i].rdy, TAG_DATA);
    end

    // Reset in the middle of a burst owned by requester 3.
    apply_reset();
    step(4'b1000, 1'b1, TAG_DATA);
    step(4'b1111, 1'b1, TAG_DATA);
    in_val = 4'b1111;
    apply_reset();
    in_val = 4'b1111; out_rdy = 1'b1; in_data = TAG_DATA;
    #1;
    chk("post_reset_grant", 0, 32'(od_b4), 32'hA0);
    chk("post_reset_rdy", 0, 32'(ir_b4), 32'h1);
    step(4'b1111, 1'b1, TAG_DATA);

    // Randomized traffic with sticky valids and occasional resets.
    rv = 4'b1111;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 249) == 0) apply_reset();
      if ($urandom_range(0, 3) == 0) rv = 4'($urandom);
      step(rv, $urandom_range(0, 3) != 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
